split_data_stream: RTL and testbench

//   Parametrised parallel-to-serial splitter between the demodulator merge stage and the UART TX path.

---
 rtl/split_data_stream.sv | 134 +++++++++++++
 tb/tb_split_data_stream.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/split_data_stream.sv
// split_data_stream
//   Parallel-to-serial splitter. A DATA_W-bit word captured on load_i is
//   emitted as DATA_W/CHUNK_W chunks of CHUNK_W bits. The chunk order is
//   MSB-first or LSB-first. Each chunk advances on a consumer next_i strobe.
//   A one-deep pending buffer accepts the following word while the current
//   word is still being sent.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous, active-high reset
//   load_i        in   strobe: data_i holds a new word
//   data_i        in   [DATA_W-1:0] word to split, sampled when load_i=1
//   next_i        in   consumer has taken chunk_o; advance to the next chunk
//   chunk_o       out  [CHUNK_W-1:0] current chunk
//   chunk_valid_o out  chunk_o is valid (a word is being sent)
//   busy_o        out  sending, or pending buffer occupied
//   done_o        out  1-cycle pulse: last chunk of a word consumed
//   overrun_o     out  1-cycle pulse: load_i dropped, pending buffer full

module split_data_stream #(
    parameter int DATA_W    = 32,
    parameter int CHUNK_W   = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [DATA_W-1:0]  data_i,
    input  logic               next_i,
    output logic [CHUNK_W-1:0] chunk_o,
    output logic               chunk_valid_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               overrun_o
);

    localparam int NCHUNK = DATA_W / CHUNK_W;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  shift_r;
    logic [DATA_W-1:0]  pend_r;
    logic               pend_v;
    logic [CNT_W-1:0]   cnt;
    logic               done_r;
    logic               overrun_r;

    logic               take_last;
    logic               load_direct;
    logic [DATA_W-1:0]  shifted;

    // Consumer takes the final chunk of the current word this cycle.
    assign take_last = (state == ACTIVE) && next_i && (cnt == LAST_CNT);

    // A load that goes straight into shift_r (back-to-back, no pending word)
    // never touches the pending buffer.
    assign load_direct = take_last && !pend_v && load_i;

    // Move the next chunk toward the output end, zero-filling behind it.
    assign shifted = MSB_FIRST ? (shift_r << CHUNK_W) : (shift_r >> CHUNK_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_r   <= '0;
            pend_r    <= '0;
            pend_v    <= 1'b0;
            cnt       <= '0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            overrun_r <= 1'b0;

            case (state)
                IDLE: begin
                    // pend_v is always clear here: IDLE is only entered
                    // once the pending buffer has been drained.
                    if (load_i) begin
                        shift_r <= data_i;
                        cnt     <= '0;
                        state   <= ACTIVE;
                    end
                end

                ACTIVE: begin
                    if (take_last) begin
                        done_r <= 1'b1;
                        cnt    <= '0;
                        if (pend_v) begin
                            shift_r <= pend_r;
                        end else if (load_i) begin
                            shift_r <= data_i;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (next_i) begin
                        shift_r <= shifted;
                        cnt     <= cnt + 1'b1;
                    end

                    // Pending buffer: a slot frees up in the same cycle the
                    // pending word moves into shift_r, so a simultaneous load
                    // refills it instead of overrunning.
                    if (load_i && !load_direct) begin
                        if (!pend_v || take_last) begin
                            pend_r <= data_i;
                            pend_v <= 1'b1;
                        end else begin
                            overrun_r <= 1'b1;
                        end
                    end else if (take_last && pend_v) begin
                        pend_v <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign chunk_o       = MSB_FIRST ? shift_r[DATA_W-1 -: CHUNK_W] : shift_r[CHUNK_W-1:0];
    assign chunk_valid_o = (state == ACTIVE);
    assign busy_o        = (state == ACTIVE) | pend_v;
    assign done_o        = done_r;
    assign overrun_o     = overrun_r;

endmodule

// File: tb/tb_split_data_stream.sv
// tb_split_data_stream
//   Directed bench for split_data_stream. Three instances share the same
//   stimulus: byte-serial MSB-first, byte-serial LSB-first and bit-serial
//   MSB-first. Each scenario starts from reset so the instances stay aligned.

module tb_split_data_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        next_i = 1'b0;

    logic [7:0]  m_chunk;
    logic        m_valid, m_busy, m_done, m_overrun;
    logic [7:0]  l_chunk;
    logic        l_valid, l_busy, l_done, l_overrun;
    logic [0:0]  b_chunk;
    logic        b_valid, b_busy, b_done, b_overrun;

    int checks = 0;
    int failures = 0;

    split_data_stream #(.DATA_W(32), .CHUNK_W(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .load_i(load_i), .data_i(data_i), .next_i(next_i),
        .chunk_o(m_chunk), .chunk_valid_o(m_valid), .busy_o(m_busy),
        .done_o(m_done), .overrun_o(m_overrun)
    );

    split_data_stream #(.DATA_W(32), .CHUNK_W(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .load_i(load_i), .data_i(data_i), .next_i(next_i),
        .chunk_o(l_chunk), .chunk_valid_o(l_valid), .busy_o(l_busy),
        .done_o(l_done), .overrun_o(l_overrun)
    );

    split_data_stream #(.DATA_W(32), .CHUNK_W(1), .MSB_FIRST(1'b1)) dut_bit (
        .clk(clk), .rst(rst), .load_i(load_i), .data_i(data_i), .next_i(next_i),
        .chunk_o(b_chunk), .chunk_valid_o(b_valid), .busy_o(b_busy),
        .done_o(b_done), .overrun_o(b_overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, let the rising edge take them, and return
    // 1 time unit later with outputs settled and the strobes cleared.
    task automatic applyStimulus(input logic load, input logic [31:0] data,
                                 input logic nxt);
        load_i = load;
        data_i = data;
        next_i = nxt;
        @(posedge clk);
        #1;
        load_i = 1'b0;
        next_i = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Step through the current byte-serial word on dut_msb, checking each chunk.
    task automatic drainMsb(input string tag, input logic [31:0] word);
        logic [31:0] w;
        w = word;
        for (int i = 0; i < 4; i++) begin
            checkOutput({tag, "_chunk"}, 32'(m_chunk), 32'(w[31-8*i -: 8]));
            applyStimulus(1'b0, 32'h0, 1'b1);
        end
    endtask

    logic [31:0] word;

    initial begin
        // ---- Reset state ----
        rst = 1'b1;
        #1;
        checkOutput("rst_chunk",   32'(m_chunk), 32'h0);
        checkOutput("rst_valid",   32'(m_valid), 32'h0);
        checkOutput("rst_busy",    32'(m_busy),  32'h0);
        checkOutput("rst_done",    32'(m_done),  32'h0);
        checkOutput("rst_overrun", 32'(m_overrun), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ---- Scenarios 1 and 2: MSB-first and LSB-first order, spaced next_i ----
        word = 32'hA1B2C3D4;
        applyStimulus(1'b1, word, 1'b0);
        checkOutput("s1_valid_after_load", 32'(m_valid), 32'h1);
        checkOutput("s2_busy_after_load",  32'(l_busy),  32'h1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0);
            checkOutput("s1_chunk", 32'(m_chunk), 32'(word[31-8*i -: 8]));
            checkOutput("s2_chunk", 32'(l_chunk), 32'(word[8*i +: 8]));
            checkOutput("s2_busy",  32'(l_busy),  32'h1);
            checkOutput("s1_done_quiet", 32'(m_done), 32'h0);
            applyStimulus(1'b0, 32'h0, 1'b1);
            checkOutput("s1_done", 32'(m_done), (i == 3) ? 32'h1 : 32'h0);
            checkOutput("s2_done", 32'(l_done), (i == 3) ? 32'h1 : 32'h0);
        end
        checkOutput("s1_idle_valid", 32'(m_valid), 32'h0);
        checkOutput("s2_idle_busy",  32'(l_busy),  32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("s1_done_once", 32'(m_done), 32'h0);

        // ---- Scenario 3: second word loaded during chunk 2, no bubble ----
        doReset();
        applyStimulus(1'b1, 32'h11223344, 1'b0);
        checkOutput("s3_c0", 32'(m_chunk), 32'h11);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("s3_c1", 32'(m_chunk), 32'h22);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("s3_c2", 32'(m_chunk), 32'h33);
        applyStimulus(1'b1, 32'h55667788, 1'b0);
        checkOutput("s3_c2_hold", 32'(m_chunk), 32'h33);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("s3_c3", 32'(m_chunk), 32'h44);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("s3_done1",  32'(m_done),  32'h1);
        checkOutput("s3_valid",  32'(m_valid), 32'h1);
        checkOutput("s3_c4",     32'(m_chunk), 32'h55);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("s3_done_q", 32'(m_done),  32'h0);
        checkOutput("s3_c5",     32'(m_chunk), 32'h66);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("s3_c6", 32'(m_chunk), 32'h77);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("s3_c7", 32'(m_chunk), 32'h88);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("s3_done2", 32'(m_done),  32'h1);
        checkOutput("s3_idle",  32'(m_valid), 32'h0);

        // ---- Scenario 4: overrun, then pending refilled on last-chunk take ----
        doReset();
        applyStimulus(1'b1, 32'hAAAA0001, 1'b0);
        applyStimulus(1'b1, 32'hBBBB0002, 1'b0);
        checkOutput("s4_no_ovr", 32'(m_overrun), 32'h0);
        applyStimulus(1'b1, 32'hCCCC0003, 1'b0);
        checkOutput("s4_ovr", 32'(m_overrun), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("s4_ovr_pulse", 32'(m_overrun), 32'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
        end
        checkOutput("s4_w1_last", 32'(m_chunk), 32'h01);
        applyStimulus(1'b1, 32'hCCDD0304, 1'b1);
        checkOutput("s4_swap_done", 32'(m_done),    32'h1);
        checkOutput("s4_swap_ovr",  32'(m_overrun), 32'h0);
        drainMsb("s4_w2", 32'hBBBB0002);
        checkOutput("s4_w2_done", 32'(m_done), 32'h1);
        drainMsb("s4_w4", 32'hCCDD0304);
        checkOutput("s4_w4_done", 32'(m_done), 32'h1);
        checkOutput("s4_idle",    32'(m_busy), 32'h0);

        // ---- Scenario 5: reset mid-word ----
        doReset();
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("s5_before", 32'(m_chunk), 32'hBE);
        rst = 1'b1;
        #1;
        checkOutput("s5_rst_chunk", 32'(m_chunk), 32'h0);
        checkOutput("s5_rst_valid", 32'(m_valid), 32'h0);
        checkOutput("s5_rst_busy",  32'(m_busy),  32'h0);
        checkOutput("s5_rst_done",  32'(m_done),  32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("s5_no_done", 32'(m_done), 32'h0);
        applyStimulus(1'b1, 32'h01020304, 1'b0);
        drainMsb("s5_new", 32'h01020304);
        checkOutput("s5_new_done", 32'(m_done), 32'h1);

        // ---- Scenario 6: bit-serial, next_i ignored in IDLE ----
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            checkOutput("s6_idle_chunk", 32'(b_chunk), 32'h0);
            checkOutput("s6_idle_valid", 32'(b_valid), 32'h0);
        end
        word = 32'h80000001;
        applyStimulus(1'b1, word, 1'b0);
        for (int i = 0; i < 32; i++) begin
            checkOutput("s6_bit", 32'(b_chunk), 32'(word[31-i]));
            checkOutput("s6_valid", 32'(b_valid), 32'h1);
            applyStimulus(1'b0, 32'h0, 1'b1);
            checkOutput("s6_done", 32'(b_done), (i == 31) ? 32'h1 : 32'h0);
        end
        checkOutput("s6_end_valid", 32'(b_valid), 32'h0);
        // shift_r keeps the value it had when the last bit was shown.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            checkOutput("s6_idle2_chunk", 32'(b_chunk), 32'h1);
            checkOutput("s6_idle2_done",  32'(b_done),  32'h0);
        end
        // A fresh load must start from bit 31, proving cnt was not disturbed.
        word = 32'h40000000;
        applyStimulus(1'b1, word, 1'b0);
        checkOutput("s6_reload_b31", 32'(b_chunk), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("s6_reload_b30", 32'(b_chunk), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: the directed sequence is fixed-length, this only guards a stall.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
